wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-stage arbiter that directly drives the register file's single write port (writeregsel, writedata, write).
- Merges two result sources: the in-order ALU pipeline, which cannot stall, and the multicycle memory unit, which returns load data through a valid/ready handshake.
- Load returns that lose arbitration are held in a small buffer and drained on idle ALU cycles.
- Write-after-write ordering to the same architectural register is enforced.

Parameters:
- DATA_WIDTH, 16, width of register data.
- REG_ADDR_W, 3, register select width (8 registers).
- DEPTH, 2, load-return buffer entries (power of two, >=2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- alu_valid  in  1  ALU result present this cycle.
- alu_regsel  in  REG_ADDR_W  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load return present.
- ld_ready  out  1  buffer can accept a load this cycle.
- ld_regsel  in  REG_ADDR_W  load destination register.
- ld_data  in  DATA_WIDTH  load data.
- writeregsel  out  REG_ADDR_W  to RF writeregsel.
- writedata  out  DATA_WIDTH  to RF writedata.
- write  out  1  to RF write enable.
- busy  out  1  buffer non-empty or write pending.
- err  out  1  sticky handshake-protocol violation.

Behaviour:
- Reset, sampled on a clock edge while rst=0: write=0, writeregsel=0, writedata=0, err=0, buffer count=0, all entry valid bits=0, ld_ready=0 during reset.
- ld_ready rises the first cycle after rst returns to 1.
- All RF-facing outputs are registered. A result accepted in cycle N appears on write/writeregsel/writedata in cycle N+1 for exactly one cycle.
- Load accept: ld_valid && ld_ready. The entry is pushed at the buffer tail the same edge.
- ld_ready = (count < DEPTH). It is driven from registered count only, with no combinational path from ld_valid or alu_valid.
- Arbitration each cycle, in priority order:
  - (1) If alu_valid, the ALU result is written next cycle.
  - (2) Otherwise, if the buffer is non-empty, the head is popped and written next cycle when its valid bit is 1. When its valid bit is 0, the head is popped silently with write=0.
  - (3) Otherwise a load accepted this cycle into an empty buffer is written directly next cycle (bypass) and is not enqueued.
  - (4) Otherwise write=0.
- WAW kill: a load return is always older than a concurrent or later ALU result.
  - When alu_valid and a buffered entry has regsel == alu_regsel, that entry's valid bit clears on the same edge. Its slot is still occupied until popped.
  - When a load is accepted in the same cycle as alu_valid with ld_regsel == alu_regsel, it is enqueued with valid=0.
- Multiple buffered entries to the same register: all are retained and written in FIFO order, so the last write wins.
- Simultaneous push and pop when full (count=DEPTH): no push, because ld_ready=0. Pop proceeds.
- Protocol check: if ld_valid=1 and ld_ready=0 in cycle N, the source must hold ld_valid, ld_regsel and ld_data unchanged in N+1. Any drop or change sets err=1, which stays set until reset.
- busy = (count != 0) || write.
- Reset mid-operation discards all buffered loads; no write is issued for them.

Decomposition:
- Shared package wb_pkg holds:
  - DATA_WIDTH and REG_ADDR_W constants, consistent with the register file.
  - typedef wb_entry_t {valid, regsel, data}.
  - localparam for buffer pointer width, clog2(DEPTH).
- One sub-module wb_buf: DEPTH-entry circular FIFO of wb_entry_t with push, pop, count, and a per-entry kill-match port (kill_en, kill_regsel).
- The arbiter, bypass, output registers and protocol checker live in wb_arbiter.

Test Plan:
- Reset: hold rst=0 for 2 cycles with alu_valid=1 -> write=0, writedata=0, ld_ready=0. After rst=1, ld_ready=1 the next cycle.
- ALU only: alu_valid=1, regsel=3, data=16'hBEEF at cycle 5 -> cycle 6 write=1, writeregsel=3, writedata=16'hBEEF; cycle 7 write=0.
- Bypass: idle ALU, ld_valid=1, regsel=5, data=16'h1234 -> next cycle write=1, regsel=5, data=16'h1234; busy=0 afterwards.
- Contention and backpressure:
  - ALU valid for 4 cycles (regsel 1, data 16'h0001..0004) while loads to regs 6, 7 arrive, then a third load (reg 2) is offered.
  - Required: ld_ready=0 after two loads, and the third load is held.
  - Drain order after the ALU burst: reg6, reg7, then reg2.
- WAW kill: buffered load to reg 4 (16'hAAAA), then alu_valid regsel=4 data=16'h5555 -> RF sees only 16'h5555 to reg 4; the killed slot pops with write=0.
- Protocol violation: ld_valid=1 while ld_ready=0, then ld_data changed next cycle -> err=1 and remains 1 until rst=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback definitions: register-file widths, load-return buffer
// sizing and the buffered entry layout.
package wb_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int REG_ADDR_W = 3;
  localparam int DEPTH      = 2;
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W      = PTR_W + 1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] regsel;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result sources (ALU, memory unit) on the master
// side and the writeback arbiter on the slave side, including the RF port.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_regsel;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_regsel;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [REG_ADDR_W-1:0] writeregsel;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  write;
  logic                  busy;
  logic                  err;

  modport master (
    output alu_valid, alu_regsel, alu_data, ld_valid, ld_regsel, ld_data,
    input  ld_ready, writeregsel, writedata, write, busy, err
  );

  modport slave (
    input  alu_valid, alu_regsel, alu_data, ld_valid, ld_regsel, ld_data,
    output ld_ready, writeregsel, writedata, write, busy, err
  );

endinterface

// File: rtl/wb_buf.sv
// Circular FIFO holding load returns that lost arbitration to the ALU.
// Entries can be invalidated in place by a younger ALU write to the same
// register; an invalidated entry keeps its slot until it is popped.
module wb_buf
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [REG_ADDR_W-1:0] kill_regsel_i,
  output wb_entry_t             head_o,
  output logic [CNT_W-1:0]      count_o
);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = entries_q[rd_ptr_q];
  assign count_o = count_q;

  // Kill matching entries, then push at tail so a fresh entry overrides a kill on its slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en_i && (entries_q[i].regsel == kill_regsel_i)) entries_q[i].valid <= 1'b0;
      end
      if (do_push) begin
        entries_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter driving the register file's single write port.
// ALU results always win; load returns are bypassed when nothing else is
// pending, otherwise buffered and drained on idle ALU cycles. A younger ALU
// write kills older buffered loads to the same register.
module wb_arbiter
  import wb_pkg::*;
(
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);

  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  ld_accept;
  logic                  buf_empty;
  logic                  pop;
  logic                  push;
  logic                  bypass;

  logic                  write_q, write_d;
  logic [REG_ADDR_W-1:0] regsel_q, regsel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  hold_q;
  logic [REG_ADDR_W-1:0] hold_regsel_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic                  err_q, err_d;

  wb_buf u_buf (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .kill_en_i     (bus.alu_valid),
    .kill_regsel_i (bus.alu_regsel),
    .head_o        (head),
    .count_o       (count)
  );

  // Pick this cycle's writer (ALU, buffer head, bypassed load, none) and compute next-state values.
  always_comb begin
    write_d    = 1'b0;
    regsel_d   = '0;
    data_d     = '0;
    push_entry = '0;

    ld_accept = bus.ld_valid && ready_q;
    buf_empty = (count == '0);
    pop       = !bus.alu_valid && !buf_empty;
    bypass    = !bus.alu_valid && buf_empty && ld_accept;
    push      = ld_accept && !bypass;

    push_entry.valid  = !(bus.alu_valid && (bus.ld_regsel == bus.alu_regsel));
    push_entry.regsel = bus.ld_regsel;
    push_entry.data   = bus.ld_data;

    if (bus.alu_valid) begin
      write_d  = 1'b1;
      regsel_d = bus.alu_regsel;
      data_d   = bus.alu_data;
    end else if (pop) begin
      write_d  = head.valid;
      regsel_d = head.regsel;
      data_d   = head.data;
    end else if (bypass) begin
      write_d  = 1'b1;
      regsel_d = bus.ld_regsel;
      data_d   = bus.ld_data;
    end

    count_next = count + CNT_W'(push) - CNT_W'(pop);
    ready_d    = (count_next < CNT_W'(DEPTH));
    err_d      = err_q || (hold_q && (!bus.ld_valid || (bus.ld_regsel != hold_regsel_q) ||
                                     (bus.ld_data != hold_data_q)));
  end

  // Register RF outputs, ready flag and the stalled-load snapshot used by the protocol check.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_q       <= 1'b0;
      regsel_q      <= '0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      hold_q        <= 1'b0;
      hold_regsel_q <= '0;
      hold_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      write_q       <= write_d;
      regsel_q      <= regsel_d;
      data_q        <= data_d;
      ready_q       <= ready_d;
      hold_q        <= bus.ld_valid && !ready_q;
      hold_regsel_q <= bus.ld_regsel;
      hold_data_q   <= bus.ld_data;
      err_q         <= err_d;
    end
  end

  assign bus.ld_ready    = ready_q;
  assign bus.write       = write_q;
  assign bus.writeregsel = regsel_q;
  assign bus.writedata   = data_q;
  assign bus.busy        = (count != '0) || write_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-scenario cycle tables push their
// expected RF writes into a scoreboard queue, popped after each clock edge.
module tb_wb_arbiter;
  import wb_pkg::*;

  typedef struct {
    logic                  av;
    logic [REG_ADDR_W-1:0] as;
    logic [DATA_WIDTH-1:0] ad;
    logic                  lv;
    logic [REG_ADDR_W-1:0] ls;
    logic [DATA_WIDTH-1:0] ld;
    logic                  rdy;
    logic                  wr;
    logic [REG_ADDR_W-1:0] ws;
    logic [DATA_WIDTH-1:0] wd;
    logic                  bz;
  } step_t;

  typedef struct {
    logic                  wr;
    logic [REG_ADDR_W-1:0] sel;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;
  exp_t expQ[$];

  wb_arbiter_if bus();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic step_t mk(input logic av, input logic [REG_ADDR_W-1:0] as,
                               input logic [DATA_WIDTH-1:0] ad, input logic lv,
                               input logic [REG_ADDR_W-1:0] ls, input logic [DATA_WIDTH-1:0] ld,
                               input logic rdy, input logic wr, input logic [REG_ADDR_W-1:0] ws,
                               input logic [DATA_WIDTH-1:0] wd, input logic bz);
    step_t s;
    s.av = av; s.as = as; s.ad = ad; s.lv = lv; s.ls = ls; s.ld = ld;
    s.rdy = rdy; s.wr = wr; s.ws = ws; s.wd = wd; s.bz = bz;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [REG_ADDR_W-1:0] as,
                       input logic [DATA_WIDTH-1:0] ad, input logic lv,
                       input logic [REG_ADDR_W-1:0] ls, input logic [DATA_WIDTH-1:0] ld);
    bus.alu_valid  = av;
    bus.alu_regsel = as;
    bus.alu_data   = ad;
    bus.ld_valid   = lv;
    bus.ld_regsel  = ls;
    bus.ld_data    = ld;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 3'd3, 16'h1111, 1'b0, 3'd0, 16'h0000);
    tick();
    tick();
    checkCount++;
    if (bus.write !== 1'b0 || bus.writedata !== 16'h0000 || bus.writeregsel !== 3'd0)
      $display("[TB] FAIL reset_outputs: got write=%b sel=%0d data=%h, expected 0/0/0000",
               bus.write, bus.writeregsel, bus.writedata);
    else passCount++;
    checkCount++;
    if (bus.ld_ready !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0)
      $display("[TB] FAIL reset_flags: got ld_ready=%b err=%b busy=%b, expected 0/0/0",
               bus.ld_ready, bus.err, bus.busy);
    else passCount++;
    rst = 1'b1;
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkCount++;
    if (bus.ld_ready !== 1'b0)
      $display("[TB] FAIL reset_release_same_cycle: got ld_ready=%b expected 0", bus.ld_ready);
    else passCount++;
    tick();
    checkCount++;
    if (bus.ld_ready !== 1'b1 || bus.write !== 1'b0)
      $display("[TB] FAIL reset_release_next: got ld_ready=%b write=%b expected 1/0",
               bus.ld_ready, bus.write);
    else passCount++;
  endtask

  task automatic run_table(input string name, input step_t st[$]);
    exp_t e;
    foreach (st[i]) begin
      drive(st[i].av, st[i].as, st[i].ad, st[i].lv, st[i].ls, st[i].ld);
      expQ.push_back('{st[i].wr, st[i].ws, st[i].wd});
      checkCount++;
      if (bus.ld_ready !== st[i].rdy)
        $display("[TB] FAIL %s_ready_c%0d: got ld_ready=%b expected %b", name, i, bus.ld_ready, st[i].rdy);
      else passCount++;
      tick();
      e = expQ.pop_front();
      checkCount++;
      if (bus.write !== e.wr || (e.wr && (bus.writeregsel !== e.sel || bus.writedata !== e.data)))
        $display("[TB] FAIL %s_write_c%0d: got write=%b sel=%0d data=%h, expected write=%b sel=%0d data=%h",
                 name, i, bus.write, bus.writeregsel, bus.writedata, e.wr, e.sel, e.data);
      else passCount++;
      checkCount++;
      if (bus.busy !== st[i].bz)
        $display("[TB] FAIL %s_busy_c%0d: got busy=%b expected %b", name, i, bus.busy, st[i].bz);
      else passCount++;
    end
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
  endtask

  task automatic test_alu_only();
    step_t st[$];
    st.push_back(mk(1, 3, 16'hBEEF, 0, 0, 16'h0000, 1, 1, 3, 16'hBEEF, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    run_table("alu_only", st);
  endtask

  task automatic test_bypass();
    step_t st[$];
    st.push_back(mk(0, 0, 16'h0000, 1, 5, 16'h1234, 1, 1, 5, 16'h1234, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    run_table("bypass", st);
  endtask

  task automatic test_contention();
    step_t st[$];
    st.push_back(mk(1, 1, 16'h0001, 1, 6, 16'h6666, 1, 1, 1, 16'h0001, 1));
    st.push_back(mk(1, 1, 16'h0002, 1, 7, 16'h7777, 1, 1, 1, 16'h0002, 1));
    st.push_back(mk(1, 1, 16'h0003, 1, 2, 16'h2222, 0, 1, 1, 16'h0003, 1));
    st.push_back(mk(1, 1, 16'h0004, 1, 2, 16'h2222, 0, 1, 1, 16'h0004, 1));
    st.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h2222, 0, 1, 6, 16'h6666, 1));
    st.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h2222, 1, 1, 7, 16'h7777, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 2, 16'h2222, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    run_table("contention", st);
    checkCount++;
    if (bus.err !== 1'b0) $display("[TB] FAIL contention_err: got err=%b expected 0", bus.err);
    else passCount++;
  endtask

  task automatic test_waw();
    step_t st[$];
    st.push_back(mk(1, 0, 16'h0F0F, 1, 4, 16'hAAAA, 1, 1, 0, 16'h0F0F, 1));
    st.push_back(mk(1, 4, 16'h5555, 0, 0, 16'h0000, 1, 1, 4, 16'h5555, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    st.push_back(mk(1, 5, 16'h0505, 1, 5, 16'hBBBB, 1, 1, 5, 16'h0505, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    run_table("waw", st);
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    st.push_back(mk(1, 0, 16'h0000, 1, 3, 16'h3001, 1, 1, 0, 16'h0000, 1));
    st.push_back(mk(1, 0, 16'h0000, 1, 3, 16'h3002, 1, 1, 0, 16'h0000, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 3, 16'h3001, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 3, 16'h3002, 1));
    st.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0));
    run_table("back_to_back", st);
  endtask

  task automatic test_protocol();
    drive(1'b1, 3'd1, 16'h0011, 1'b1, 3'd6, 16'h6666);
    tick();
    drive(1'b1, 3'd1, 16'h0012, 1'b1, 3'd7, 16'h7777);
    tick();
    drive(1'b1, 3'd1, 16'h0013, 1'b1, 3'd2, 16'h2222);
    checkCount++;
    if (bus.ld_ready !== 1'b0) $display("[TB] FAIL protocol_full: got ld_ready=%b expected 0", bus.ld_ready);
    else passCount++;
    tick();
    checkCount++;
    if (bus.err !== 1'b0) $display("[TB] FAIL protocol_no_err_yet: got err=%b expected 0", bus.err);
    else passCount++;
    drive(1'b1, 3'd1, 16'h0014, 1'b1, 3'd2, 16'h2223);
    tick();
    checkCount++;
    if (bus.err !== 1'b1) $display("[TB] FAIL protocol_err_set: got err=%b expected 1", bus.err);
    else passCount++;
    drive(1'b1, 3'd1, 16'h0015, 1'b0, 3'd0, 16'h0000);
    tick();
    checkCount++;
    if (bus.err !== 1'b1) $display("[TB] FAIL protocol_err_sticky: got err=%b expected 1", bus.err);
    else passCount++;
    rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    tick();
    checkCount++;
    if (bus.err !== 1'b0 || bus.write !== 1'b0 || bus.busy !== 1'b0 || bus.ld_ready !== 1'b0)
      $display("[TB] FAIL protocol_reset: got err=%b write=%b busy=%b ld_ready=%b expected 0/0/0/0",
               bus.err, bus.write, bus.busy, bus.ld_ready);
    else passCount++;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkCount++;
      if (bus.write !== 1'b0 || bus.busy !== 1'b0)
        $display("[TB] FAIL discard_after_reset_c%0d: got write=%b busy=%b expected 0/0",
                 c, bus.write, bus.busy);
      else passCount++;
    end
  endtask

  initial begin
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    test_reset();
    test_alu_only();
    test_bypass();
    test_contention();
    test_waw();
    test_back_to_back();
    test_protocol();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
